// File: rtl/muldiv_unit.sv
// Iterative 32-cycle shift-add multiplier / restoring divider with sign fix-up,
// delivering hi/lo plus a one-cycle write pulse 33 edges after acceptance.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             flush,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic             hi_lo_we,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count;
  logic [W2-1:0]    acc;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             is_div, sign_a, neg_res;

  logic             accept, last_iter, is_signed;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic [WIDTH:0]   mul_sum, rem_sh;
  logic [WIDTH+1:0] diff;
  logic [W2-1:0]    mul_step, div_step, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix, a_raw;

  assign accept    = (state == IDLE) && start && !flush;
  assign last_iter = (count == CNT_W'(WIDTH - 1));
  assign is_signed = ~op[0];
  assign rs_mag    = (is_signed && rs_data[WIDTH-1]) ? -rs_data : rs_data;
  assign rt_mag    = (is_signed && rt_data[WIDTH-1]) ? -rt_data : rt_data;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign mul_sum  = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);
  assign mul_step = {mul_sum, acc[WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend bits shifting out / quotient bits in}.
  assign rem_sh   = {acc[W2-1:WIDTH], acc[WIDTH-1]};
  assign diff     = {1'b0, rem_sh} - {2'b00, b_mag};
  assign div_step = diff[WIDTH+1] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                  : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  assign prod_fix = neg_res ? -acc : acc;
  assign quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = sign_a ? -acc[W2-1:WIDTH] : acc[W2-1:WIDTH];
  assign a_raw    = sign_a ? -a_mag : a_mag;

  assign hi_lo_we = done;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC: begin
        if (flush)          state_nxt = IDLE;
        else if (last_iter) state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      acc     <= '0;
      a_mag   <= '0;
      b_mag   <= '0;
      is_div  <= 1'b0;
      sign_a  <= 1'b0;
      neg_res <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            a_mag   <= rs_mag;
            b_mag   <= rt_mag;
            is_div  <= op[1];
            sign_a  <= is_signed & rs_data[WIDTH-1];
            neg_res <= is_signed & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
            acc     <= op[1] ? {{WIDTH{1'b0}}, rs_mag} : {{WIDTH{1'b0}}, rt_mag};
            count   <= '0;
            busy    <= 1'b1;
          end
        end
        CALC: begin
          if (flush) begin
            busy <= 1'b0;
          end else begin
            acc   <= is_div ? div_step : mul_step;
            count <= count + 1'b1;
          end
        end
        FIX: begin
          busy <= 1'b0;
          if (!flush) begin
            done <= 1'b1;
            if (!is_div) begin
              hi <= prod_fix[W2-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end else if (b_mag == '0) begin
              // Divide by zero reports the untouched dividend and an all-ones quotient.
              hi <= a_raw;
              lo <= '1;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end
        end
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule
